// File: rtl/sobel_pkg.sv
// sobel_pkg: scan-sequencer state encoding and 3x3 tap offset tables.
package sobel_pkg;
  localparam int TAPS = 9;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_WIN, S_WRITE, S_DONE} state_t;
  // Row/column offsets stored biased by +1 (0,1,2 mean -1,0,+1); tap k sits in bits [2k+1:2k].
  localparam logic [2*TAPS-1:0] TAP_DR = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [2*TAPS-1:0] TAP_DC = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
endpackage

// File: rtl/sobel_addr_gen.sv
// sobel_addr_gen: maps centre (row, col) and tap index to the tap read address and the centre address.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int AW    = 12
) (
  input  logic [AW-1:0] i_row,
  input  logic [AW-1:0] i_col,
  input  logic [3:0]    i_tap,
  output logic [AW-1:0] o_rd_addr,
  output logic [AW-1:0] o_ctr_addr
);
  localparam logic [AW-1:0] W = AW'(IMG_W);
  logic [1:0]    w_dr, w_dc;
  logic [AW-1:0] w_row, w_col;
  assign w_dr       = TAP_DR[{i_tap, 1'b0} +: 2];
  assign w_dc       = TAP_DC[{i_tap, 1'b0} +: 2];
  assign w_row      = i_row + AW'(w_dr) - AW'(1);
  assign w_col      = i_col + AW'(w_dc) - AW'(1);
  assign o_rd_addr  = w_row * W + w_col;
  assign o_ctr_addr = i_row * W + i_col;
endmodule

// File: rtl/sobel_scan_ctrl.sv
// sobel_scan_ctrl: walks interior pixels, fetches each 3x3 window one tap per cycle,
// hands it to the Sobel core over valid/ready and writes the edge bit at the centre address.
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  parameter int AW    = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            thr_in,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [PIX_W-1:0]      rd_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [TAPS*PIX_W-1:0] win_data,
  output logic [7:0]            thr,
  input  logic                  edge_in,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic                  wr_data
);
  localparam logic [AW-1:0] LAST_I = AW'(IMG_H - 2);
  localparam logic [AW-1:0] LAST_J = AW'(IMG_W - 2);
  state_t                r_state;
  logic [AW-1:0]         r_i, r_j, r_wr_addr, w_rd_addr, w_ctr_addr;
  logic [3:0]            r_k;
  logic                  r_busy, r_done, r_rd_en, r_win_valid, r_wr_en, r_wr_data;
  logic [TAPS*PIX_W-1:0] r_win;
  logic [7:0]            r_thr;
  logic                  w_last_px, w_row_end;
  assign w_last_px = (r_i == LAST_I) && (r_j == LAST_J);
  assign w_row_end = r_j == LAST_J;
  sobel_addr_gen #(.IMG_W(IMG_W), .AW(AW)) u_addr_gen (
    .i_row     (r_i),
    .i_col     (r_j),
    .i_tap     (r_k),
    .o_rd_addr (w_rd_addr),
    .o_ctr_addr(w_ctr_addr)
  );
  // Indices park at (1,1,0) outside a frame, so rd_addr reads 0 while idle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_i         <= AW'(1);
      r_j         <= AW'(1);
      r_k         <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_win_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 1'b0;
      r_win       <= '0;
      r_thr       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_thr   <= thr_in;
          r_i     <= AW'(1);
          r_j     <= AW'(1);
          r_k     <= 4'd0;
          r_busy  <= 1'b1;
          r_rd_en <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (r_k != 4'd0) r_win[(32'(r_k) - 1) * PIX_W +: PIX_W] <= rd_data;
          if (r_k == 4'd8) begin
            r_rd_en <= 1'b0;
            r_state <= S_LAST;
          end else r_k <= r_k + 4'd1;
        end
        S_LAST: begin
          r_win[8*PIX_W +: PIX_W] <= rd_data;
          r_win_valid <= 1'b1;
          r_state     <= S_WIN;
        end
        S_WIN: if (win_ready) begin
          r_win_valid <= 1'b0;
          r_wr_en     <= 1'b1;
          r_wr_addr   <= w_ctr_addr;
          r_wr_data   <= edge_in;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          r_k     <= 4'd0;
          if (w_last_px) begin
            r_i     <= AW'(1);
            r_j     <= AW'(1);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_j     <= w_row_end ? AW'(1) : r_j + AW'(1);
            r_i     <= w_row_end ? r_i + AW'(1) : r_i;
            r_rd_en <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr   = w_rd_addr;
  assign win_valid = r_win_valid;
  assign win_data  = r_win;
  assign thr       = r_thr;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// tb_sobel_scan_ctrl: directed checks of the scan sequencer on a 4x4 frame and a full 64x64 frame.
`timescale 1ns/1ps
module tb_sobel_scan_ctrl;
  localparam int AW = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic          a_start = 0, a_win_ready = 0, a_edge_in = 0;
  logic [7:0]    a_thr_in = 0, a_thr, a_rd_data = 0;
  logic          a_busy, a_done, a_rd_en, a_win_valid, a_wr_en, a_wr_data;
  logic [AW-1:0] a_rd_addr, a_wr_addr;
  logic [71:0]   a_win_data, w0;

  logic          b_start = 0, b_win_ready = 1, b_edge_in = 1;
  logic [7:0]    b_thr_in = 0, b_thr, b_rd_data = 0;
  logic          b_busy, b_done, b_rd_en, b_win_valid, b_wr_en, b_wr_data;
  logic [AW-1:0] b_rd_addr, b_wr_addr;
  logic [71:0]   b_win_data;

  sobel_scan_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .AW(AW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .thr_in(a_thr_in), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .win_valid(a_win_valid),
    .win_ready(a_win_ready), .win_data(a_win_data), .thr(a_thr), .edge_in(a_edge_in),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  sobel_scan_ctrl #(.IMG_W(64), .IMG_H(64), .PIX_W(8), .AW(AW)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .thr_in(b_thr_in), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .win_valid(b_win_valid),
    .win_ready(b_win_ready), .win_data(b_win_data), .thr(b_thr), .edge_in(b_edge_in),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  // Image memories hold mem[a] = a, one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_rd_addr[7:0];
    if (b_rd_en) b_rd_data <= b_rd_addr[7:0];
  end

  int a_rdq[$], a_wrq[$], a_wdq[$];
  int a_done_cnt = 0, a_excl_err = 0;
  always @(negedge clk) begin
    if (a_rd_en) a_rdq.push_back(int'(a_rd_addr));
    if (a_wr_en) begin
      a_wrq.push_back(int'(a_wr_addr));
      a_wdq.push_back(int'(a_wr_data));
    end
    if (a_done) a_done_cnt++;
    if (int'(a_rd_en) + int'(a_win_valid) + int'(a_wr_en) > 1) a_excl_err++;
  end

  int b_wr_cnt = 0, b_last = -1, b_border = 0, b_order_err = 0, b_done_cnt = 0, b_excl_err = 0;
  int b_exp_i = 1, b_exp_j = 1, b_a;
  always @(negedge clk) begin
    if (b_wr_en) begin
      b_a = int'(b_wr_addr);
      b_wr_cnt++;
      b_last = b_a;
      if (b_a / 64 == 0 || b_a / 64 == 63 || b_a % 64 == 0 || b_a % 64 == 63) b_border++;
      if (b_a != b_exp_i * 64 + b_exp_j) b_order_err++;
      if (b_exp_j == 62) begin
        b_exp_j = 1;
        b_exp_i++;
      end else b_exp_j++;
    end
    if (b_done) b_done_cnt++;
    if (int'(b_rd_en) + int'(b_win_valid) + int'(b_wr_en) > 1) b_excl_err++;
  end

  int ctrs[4] = '{5, 6, 9, 10};
  int first_taps[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int cnt, n_wr;

  initial begin
    repeat (3) tick();
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rd_en", a_rd_en, 0);
    check("rst_rd_addr", a_rd_addr, 0);
    check("rst_win_valid", a_win_valid, 0);
    check("rst_wr_en", a_wr_en, 0);
    check("rst_wr_addr", a_wr_addr, 0);
    check("rst_thr", a_thr, 0);
    check("rst_win_lo", a_win_data[31:0], 0);
    rst_n = 1'b1;
    tick();

    // Frame 1: 4x4, backpressure on the first window, stray start while busy.
    a_thr_in = 8'd27;
    a_start  = 1'b1;
    tick();
    a_start  = 1'b0;
    a_thr_in = 8'd0;
    check("f1_busy", a_busy, 1);
    for (int c = 0; c < 40 && !a_win_valid; c++) tick();
    check("f1_win_valid", a_win_valid, 1);
    check("f1_rd_count", a_rdq.size(), 9);
    for (int k = 0; k < 9 && k < a_rdq.size(); k++) check($sformatf("f1_rd_addr%0d", k), a_rdq[k], first_taps[k]);
    for (int k = 0; k < 9; k++) check($sformatf("f1_tap%0d", k), a_win_data[k*8 +: 8], first_taps[k]);
    check("f1_thr", a_thr, 27);
    w0 = a_win_data;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        a_start  = 1'b1;
        a_thr_in = 8'd99;
      end
      tick();
      a_start = 1'b0;
      check("bp_valid", a_win_valid, 1);
      check("bp_data", a_win_data === w0, 1);
      check("bp_rd_en", a_rd_en, 0);
      check("bp_wr_en", a_wr_en, 0);
    end
    check("bp_thr_kept", a_thr, 27);
    a_win_ready = 1'b1;
    a_edge_in   = 1'b1;
    tick();
    check("bp_wr_en_after", a_wr_en, 1);
    check("bp_wr_addr", a_wr_addr, 5);
    check("bp_wr_data", a_wr_data, 1);
    for (int c = 0; c < 200 && !a_done; c++) tick();
    check("f1_done", a_done, 1);
    check("f1_busy_at_done", a_busy, 0);
    tick();
    check("f1_done_pulse", a_done, 0);
    check("f1_busy_after", a_busy, 0);
    check("f1_done_cnt", a_done_cnt, 1);
    check("f1_wr_count", a_wrq.size(), 4);
    for (int p = 0; p < 4 && p < a_wrq.size(); p++) begin
      check($sformatf("f1_wr_addr%0d", p), a_wrq[p], ctrs[p]);
      check($sformatf("f1_wr_data%0d", p), a_wdq[p], 1);
    end
    check("f1_rd_total", a_rdq.size(), 36);
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 9; k++)
        if (p * 9 + k < a_rdq.size())
          check($sformatf("f1_scan%0d", p * 9 + k), a_rdq[p*9+k], ctrs[p] + (k / 3 - 1) * 4 + (k % 3 - 1));
    check("f1_thr_end", a_thr, 27);

    // Frame 2: no backpressure, latency and edge=0 data.
    a_rdq.delete(); a_wrq.delete(); a_wdq.delete();
    a_done_cnt = 0;
    a_edge_in  = 1'b0;
    a_thr_in   = 8'd5;
    a_start    = 1'b1;
    tick();
    a_start = 1'b0;
    cnt = 1;
    while (!a_done && cnt < 200) begin
      tick();
      cnt++;
    end
    check("f2_latency", cnt, 4 * 12 + 1);
    check("f2_thr", a_thr, 5);
    tick();
    check("f2_done_cnt", a_done_cnt, 1);
    check("f2_wr_count", a_wrq.size(), 4);
    for (int p = 0; p < 4 && p < a_wrq.size(); p++) begin
      check($sformatf("f2_wr_addr%0d", p), a_wrq[p], ctrs[p]);
      check($sformatf("f2_wr_data%0d", p), a_wdq[p], 0);
    end

    // Frame 3: reset mid-frame, then restart from (1,1).
    a_edge_in = 1'b1;
    a_thr_in  = 8'd27;
    a_start   = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (20) tick();
    check("f3_busy_pre", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", a_busy, 0);
    check("mr_rd_en", a_rd_en, 0);
    check("mr_rd_addr", a_rd_addr, 0);
    check("mr_win_valid", a_win_valid, 0);
    check("mr_wr_en", a_wr_en, 0);
    check("mr_wr_addr", a_wr_addr, 0);
    check("mr_wr_data", a_wr_data, 0);
    check("mr_thr", a_thr, 0);
    check("mr_win_lo", a_win_data[31:0], 0);
    tick();
    rst_n = 1'b1;
    n_wr = a_wrq.size();
    repeat (30) tick();
    check("mr_no_writes", a_wrq.size(), n_wr);
    check("mr_idle_busy", a_busy, 0);
    a_rdq.delete(); a_wrq.delete(); a_wdq.delete();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 200 && !a_done; c++) tick();
    check("f4_done", a_done, 1);
    check("f4_first_rd", a_rdq.size() > 0 ? a_rdq[0] : -1, 0);
    check("f4_first_wr", a_wrq.size() > 0 ? a_wrq[0] : -1, 5);
    check("f4_wr_count", a_wrq.size(), 4);
    check("a_exclusive", a_excl_err, 0);

    // Full 64x64 frame.
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 1;
    while (!b_done && cnt < 50000) begin
      tick();
      cnt++;
    end
    check("b_latency", cnt, 3844 * 12 + 1);
    tick();
    check("b_wr_count", b_wr_cnt, 3844);
    check("b_last_addr", b_last, 4030);
    check("b_border", b_border, 0);
    check("b_order", b_order_err, 0);
    check("b_done_cnt", b_done_cnt, 1);
    check("b_busy_after", b_busy, 0);
    check("b_exclusive", b_excl_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
